// File: rtl/msr_link_pkg.sv
// Shared types for the measurement byte link: word geometry, FSM states, byte index and byte picker.
// Pure declarations; no clocked logic, no flow control.
package msr_link_pkg;

    localparam int MSR_W          = 24;
    localparam int BYTES_PER_WORD = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

    // Index 3 never occurs; it folds onto the top byte so the mux stays total.
    function automatic logic [7:0] word_byte(input logic [MSR_W-1:0] w, input byte_idx_t idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            default: b = w[23:16];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/msr_byte_link_if.sv
// Capture-side and Pi-side signals of the byte link; master = capture block / Pi, slave = msr_byte_link.
// No logic; gpio_par exists only when MSR_LINK_PARITY_EN is defined.
interface msr_byte_link_if;
    import msr_link_pkg::*;

    logic             msr_valid;
    logic [MSR_W-1:0] msr_data;
    logic             gpio_req;
    logic             gpio_ack;
    logic [7:0]       gpio_data;
    byte_idx_t        gpio_idx;
    logic             word_avail;
    logic             overflow;
    logic             ovf_clr;
`ifdef MSR_LINK_PARITY_EN
    logic             gpio_par;
`endif

    modport master (
        output msr_valid, msr_data, gpio_req, ovf_clr,
`ifdef MSR_LINK_PARITY_EN
        input  gpio_par,
`endif
        input  gpio_ack, gpio_data, gpio_idx, word_avail, overflow
    );

    modport slave (
        input  msr_valid, msr_data, gpio_req, ovf_clr,
`ifdef MSR_LINK_PARITY_EN
        output gpio_par,
`endif
        output gpio_ack, gpio_data, gpio_idx, word_avail, overflow
    );

endinterface

// File: rtl/msr_fifo.sv
// Synchronous FIFO, head presented from the registered read pointer; one cycle push-to-visible.
// A push while full is taken only when a pop lands in the same cycle; otherwise it is ignored.
module msr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // When full, write and read pointers coincide; the popped slot is the one refilled.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/msr_byte_link.sv
// Buffers 24-bit captures and serves them LSB byte first over a Pi-driven 4-phase req/ack link (MSR_LINK_PARITY_EN adds gpio_par).
// req->ack rise 3+SETUP_CYC cycles, fall 3; capture side never stalls: a full FIFO drops the word and sets sticky overflow.
module msr_byte_link
    import msr_link_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    msr_byte_link_if.slave bus
);
    localparam int               CNT_W    = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETUP_CYC - 1);

    state_e           state_q, state_d;
    byte_idx_t        idx_q, idx_d;
    byte_idx_t        gidx_q, gidx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             ack_q, ack_d;
    logic             pop_q, pop_d;
    logic             ovf_q, ovf_d;
    logic             req_m_q, req_m_d;
    logic             req_s_q, req_s_d;
    logic             launch, drop;
    logic             fifo_full, fifo_empty;
    logic [MSR_W-1:0] head;
`ifdef MSR_LINK_PARITY_EN
    logic             par_q, par_d;
`endif

    msr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MSR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.msr_valid),
        .pop   (pop_q),
        .din   (bus.msr_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        req_m_d = bus.gpio_req;
        req_s_d = req_m_q;
        drop    = bus.msr_valid && fifo_full && !pop_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // The pop lands one cycle after ack falls; until then the head is stale and must not relaunch.
    assign launch = (state_q == ST_IDLE) && req_s_q && !fifo_empty && !pop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            pop_q   <= 1'b0;
            ovf_q   <= 1'b0;
            req_m_q <= 1'b0;
            req_s_q <= 1'b0;
`ifdef MSR_LINK_PARITY_EN
            par_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            pop_q   <= pop_d;
            ovf_q   <= ovf_d;
            req_m_q <= req_m_d;
            req_s_q <= req_s_d;
`ifdef MSR_LINK_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (launch) state_d = ST_SETUP;
            ST_SETUP: if (cnt_q == CNT_LAST) state_d = ST_ACK;
            ST_ACK:   if (!req_s_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        gidx_d = gidx_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        ack_d  = ack_q;
        pop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    cnt_d  = '0;
                    data_d = word_byte(head, idx_q);
                    gidx_d = idx_q;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    ack_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (!req_s_q) begin
                    ack_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        pop_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + byte_idx_t'(1);
                    end
                end
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

`ifdef MSR_LINK_PARITY_EN
    assign par_d        = ~^{gidx_d, data_d};
    assign bus.gpio_par = par_q;
`endif

    assign bus.gpio_ack   = ack_q;
    assign bus.gpio_data  = data_q;
    assign bus.gpio_idx   = gidx_q;
    assign bus.word_avail = !fifo_empty;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_msr_byte_link.sv
// Random and directed traffic against a queue model of the link; a negedge monitor scores every ack rise.
module tb_msr_byte_link;
    import msr_link_pkg::*;

    localparam int DEPTH     = 4;
    localparam int SETUP_CYC = 4;
    localparam int LIMIT     = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msr_byte_link_if bus();

    msr_byte_link #(
        .DEPTH     (DEPTH),
        .SETUP_CYC (SETUP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          errors = 0;
    int          checks = 0;
    logic [23:0] mdl_q[$];
    logic [9:0]  exp_q[$];
    bit          mdl_ovf = 1'b0;
    int          mdl_idx = 0;
    bit          ack_prev = 1'b0;
    logic [9:0]  e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Words that fit are queued and their three bytes become expected ack-rise responses.
    function automatic void model_push(input logic [23:0] w, input bit clr);
        bit drop = (mdl_q.size() >= DEPTH);
        if (!drop) begin
            mdl_q.push_back(w);
            for (int b = 0; b < 3; b++) exp_q.push_back({2'(b), w[8*b +: 8]});
        end
        if (drop) mdl_ovf = 1'b1;
        else if (clr) mdl_ovf = 1'b0;
    endfunction

    function automatic void finish_model_byte();
        mdl_idx++;
        if (mdl_idx == 3) begin
            mdl_idx = 0;
            void'(mdl_q.pop_front());
        end
    endfunction

    task automatic push_word(input logic [23:0] w, input bit clr);
        @(posedge clk); #1;
        bus.msr_valid = 1'b1;
        bus.msr_data  = w;
        bus.ovf_clr   = clr;
        model_push(w, clr);
        @(posedge clk); #1;
        bus.msr_valid = 1'b0;
        bus.ovf_clr   = 1'b0;
    endtask

    task automatic clear_ovf();
        @(posedge clk); #1;
        bus.ovf_clr = 1'b1;
        mdl_ovf     = 1'b0;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        while (bus.gpio_ack !== lvl && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        chk(lvl ? "ack_rise_bound" : "ack_fall_bound", 32'(bus.gpio_ack), 32'(lvl));
    endtask

    task automatic pi_byte(input bit push_fall, input logic [23:0] pw);
        int n;
        @(posedge clk); #1;
        bus.gpio_req = 1'b1;
        wait_ack(1'b1, n);
        chk("req_to_ack_rise", 32'(n), 32'(3 + SETUP_CYC));
        bus.gpio_req = 1'b0;
        wait_ack(1'b0, n);
        chk("req_to_ack_fall", 32'(n), 32'd3);
        finish_model_byte();
        if (push_fall) begin
            bus.msr_valid = 1'b1;
            bus.msr_data  = pw;
            model_push(pw, 1'b0);
            @(posedge clk); #1;
            bus.msr_valid = 1'b0;
        end
    endtask

    task automatic read_word();
        repeat (3) pi_byte(1'b0, 24'h0);
    endtask

    task automatic check_flags(input string tag);
        @(posedge clk); #1;
        chk({tag, "_word_avail"}, 32'(bus.word_avail), 32'(mdl_q.size() != 0));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(mdl_ovf));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ack_prev = 1'b0;
        end else begin
            if (bus.gpio_ack && !ack_prev) begin
                chk("ack_has_pending_byte", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("byte_data", 32'(bus.gpio_data), 32'(e[7:0]));
                    chk("byte_idx", 32'(bus.gpio_idx), 32'(e[9:8]));
                end
`ifdef MSR_LINK_PARITY_EN
                chk("odd_parity", 32'(^{bus.gpio_idx, bus.gpio_data, bus.gpio_par}), 32'd1);
`endif
            end
            ack_prev = bus.gpio_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [23:0] w;
        bus.msr_valid = 1'b0;
        bus.msr_data  = '0;
        bus.gpio_req  = 1'b0;
        bus.ovf_clr   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(bus.gpio_ack), 32'd0);
        chk("rst_data", 32'(bus.gpio_data), 32'd0);
        chk("rst_idx", 32'(bus.gpio_idx), 32'd0);
        chk("rst_avail", 32'(bus.word_avail), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
`ifdef MSR_LINK_PARITY_EN
        chk("rst_par", 32'(bus.gpio_par), 32'd1);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word: C3/B2/A1, word_avail drops one cycle after the last ack fall.
        push_word(24'hA1B2C3, 1'b0);
        check_flags("single_loaded");
        read_word();
        chk("avail_at_last_ack_fall", 32'(bus.word_avail), 32'd1);
        @(posedge clk); #1;
        chk("avail_after_pop", 32'(bus.word_avail), 32'd0);

        // Stall: req held high against an empty FIFO.
        @(posedge clk); #1;
        bus.gpio_req = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("stall_ack_low", 32'(bus.gpio_ack), 32'd0);
        bus.msr_valid = 1'b1;
        bus.msr_data  = 24'h000001;
        model_push(24'h000001, 1'b0);
        @(posedge clk); #1;
        bus.msr_valid = 1'b0;
        wait_ack(1'b1, n);
        chk("push_to_ack_rise", 32'(n), 32'(1 + SETUP_CYC));
        bus.gpio_req = 1'b0;
        wait_ack(1'b0, n);
        chk("stall_ack_fall", 32'(n), 32'd3);
        finish_model_byte();
        pi_byte(1'b0, 24'h0);
        pi_byte(1'b0, 24'h0);
        check_flags("stall_done");

        // Overflow: fifth word dropped, clear coincident with a drop loses to the set.
        for (int i = 0; i < 5; i++) push_word(24'h10 + 24'(i), 1'b0);
        check_flags("ovf_set");
        push_word(24'h55, 1'b1);
        check_flags("ovf_clr_vs_drop");
        clear_ovf();
        check_flags("ovf_cleared");
        repeat (4) read_word();
        check_flags("ovf_drained");

        // Full FIFO, push lands on the cycle of the final-byte pop.
        push_word(24'h000000, 1'b0);
        for (int i = 0; i < 3; i++) push_word(24'($urandom), 1'b0);
        pi_byte(1'b0, 24'h0);
        pi_byte(1'b0, 24'h0);
        pi_byte(1'b1, 24'h5A5A5A);
        check_flags("pop_push_full");
        push_word(24'hDEAD01, 1'b0);
        check_flags("still_full");
        clear_ovf();
        repeat (4) read_word();
        check_flags("pop_push_drained");

        // Reset while acknowledging byte 1.
        push_word(24'h123456, 1'b0);
        pi_byte(1'b0, 24'h0);
        @(posedge clk); #1;
        bus.gpio_req = 1'b1;
        wait_ack(1'b1, n);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(bus.gpio_ack), 32'd0);
        chk("midrst_idx", 32'(bus.gpio_idx), 32'd0);
        chk("midrst_avail", 32'(bus.word_avail), 32'd0);
        mdl_q.delete();
        exp_q.delete();
        mdl_idx      = 0;
        mdl_ovf      = 1'b0;
        bus.gpio_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_word(24'hFFFFFF, 1'b0);
        read_word();
        check_flags("after_reset");

        // Random bursts, occasionally overrunning the FIFO, then drained by the Pi.
        for (int r = 0; r < 10; r++) begin
            int k;
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                w = 24'($urandom);
                push_word(w, 1'b0);
            end
            check_flags("rand_filled");
            if (mdl_ovf) clear_ovf();
            while (mdl_q.size() != 0) read_word();
            check_flags("rand_drained");
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msr_byte_link.md
Name: msr_byte_link

Overview:
- Downstream stage of the timer-capture block (24-bit measurement capture).
- Buffers captured 24-bit measurements in a small FIFO.
- Ships each measurement to the Raspberry Pi over an 8-bit GPIO bus, 3 bytes per word, LSB byte first.
- Uses a 4-phase req/ack handshake driven by the Pi; runs in the 100 MHz PLL domain.

Parameters:
- DEPTH, 4, FIFO depth in 24-bit words; power of 2, minimum 2.
- SETUP_CYC, 4, clk cycles gpio_data/gpio_idx are stable before gpio_ack rises; minimum 1.

Ports:
- clk  in  1  100 MHz PLL clock
- rst_n  in  1  asynchronous, active-low reset
- msr_valid  in  1  single-cycle pulse; msr_data valid this cycle
- msr_data  in  24  captured timer value
- gpio_req  in  1  Pi request; asynchronous to clk
- gpio_ack  out  1  byte valid acknowledge to the Pi
- gpio_data  out  8  current byte
- gpio_idx  out  2  byte index of gpio_data (0 = bits 7:0, 1 = 15:8, 2 = 23:16)
- word_avail  out  1  FIFO not empty
- overflow  out  1  sticky: a word was dropped
- ovf_clr  in  1  single-cycle clear of overflow

Behaviour:
- Reset (async assert, synchronous release): gpio_ack=0, gpio_data=0, gpio_idx=0, word_avail=0, overflow=0. FIFO empty, byte index 0, FSM in IDLE, synchroniser flops 0.
- gpio_req passes through a 2-flop synchroniser (req_s). All handshake decisions use req_s only.
- Push:
  - msr_valid with FIFO not full writes msr_data.
  - msr_valid with FIFO full is accepted only if a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set.
  - overflow stays set until ovf_clr. A set and a clear in the same cycle: set wins.
- word_avail reflects FIFO occupancy from registered state: high the cycle after the first push, low the cycle after the last pop.
- FSM states IDLE, SETUP, ACK:
  - IDLE: if req_s=1 and FIFO not empty, drive gpio_data = head[8*idx+7 : 8*idx] and gpio_idx = idx. Clear the setup counter and go to SETUP. If req_s=1 and FIFO is empty, stay in IDLE with ack low (stall). Resume when a word arrives.
  - SETUP: count SETUP_CYC cycles, then gpio_ack<=1 and go to ACK.
  - ACK: hold until req_s=0. Then gpio_ack<=0.
    - If idx=2: pop the FIFO head and set idx<=0.
    - Otherwise idx<=idx+1.
    - Go to IDLE.
- gpio_data and gpio_idx change only on the IDLE->SETUP transition and hold their values in between.
- Latency: gpio_req rise to gpio_ack rise = 2 (sync) + 1 + SETUP_CYC clk cycles. gpio_req fall to gpio_ack fall = 3 cycles.
- The head word is not removed until its third byte completes its handshake. A Pi abort leaves the word in place.
- Pop plus push in the same cycle at any occupancy: occupancy is unchanged and both operations take effect.
- FIFO pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Reset mid-transfer: the in-flight word and all buffered words are lost, and ack drops asynchronously. The Pi must restart at idx 0; gpio_idx=0 after reset indicates this.

Optional Feature:
- Macro MSR_LINK_PARITY_EN.
- When defined: adds output gpio_par (1 bit), registered alongside gpio_data. It is the odd parity over {gpio_idx, gpio_data}, so the XOR of all 11 bits is 1. Reset value is 1 (odd parity of zeros).
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package msr_link_pkg holds:
  - MSR_W=24
  - BYTES_PER_WORD=3
  - state typedef (IDLE/SETUP/ACK)
  - byte-index typedef (2 bits)
- Sub-module msr_fifo: a synchronous FIFO with DEPTH and width parameters.
  - Ports: push, pop, din, dout (head, registered read pointer), full, empty.
  - Resets on rst_n.
- The FSM, synchroniser and overflow flag live in msr_byte_link.

Test Plan:
- Single word: push 0xA1B2C3, Pi runs 3 handshakes. Bytes read are 0xC3/idx0, 0xB2/idx1, 0xA1/idx2. word_avail falls 1 cycle after the third ack fall. Each ack rises exactly 3+SETUP_CYC cycles after its req rise.
- Stall: Pi raises req with the FIFO empty, and msr_valid arrives 20 cycles later with 0x000001. ack stays low until the push, then rises with gpio_data=0x01 and idx=0.
- Overflow: DEPTH=4, push 5 words 0x10..0x14 with no Pi activity. overflow=1, and the 4 words read back are 0x10..0x13. ovf_clr clears the flag. ovf_clr coincident with a drop leaves overflow=1.
- Full with simultaneous pop: FIFO full, msr_valid lands on the cycle of the final-byte pop. The word is accepted, overflow stays 0, and occupancy remains 4.
- Reset mid-transfer: assert rst_n low while in ACK at idx=1. ack=0 and idx=0 immediately, word_avail=0. A new push 0xFFFFFF is then read out correctly as FF/FF/FF.
- With MSR_LINK_PARITY_EN: byte 0x00 at idx0 gives gpio_par=1; byte 0x01 at idx0 gives gpio_par=0. The XOR of all 11 bits is checked as 1 on every ack rise.
